// File: rtl/ulpi_phy_model_if.sv
// rtl/ulpi_phy_model_if.sv - ULPI pin bundle plus side-band injection and register/TX status
// master = link/bench side, slave = the emulated PHY.
interface ulpi_phy_model_if #(
   parameter int REG_ADDR_W = 6,
   parameter int TXCNT_W    = 11
);
   logic                  ulpi_resetn;
   logic [7:0]            ulpi_data_i;
   logic [7:0]            ulpi_data_o;
   logic                  ulpi_data_oe;
   logic                  ulpi_dir;
   logic                  ulpi_nxt;
   logic                  ulpi_stp;
   logic                  inj_valid;
   logic [7:0]            inj_data;
   logic                  inj_last;
   logic                  inj_ready;
   logic                  rxcmd_req;
   logic [7:0]            rxcmd_val;
   logic                  reg_wr_stb;
   logic [REG_ADDR_W-1:0] reg_wr_addr;
   logic [7:0]            reg_wr_data;
   logic [TXCNT_W-1:0]    tx_bytes;

   modport slave (
      input  ulpi_resetn, ulpi_data_i, ulpi_stp, inj_valid, inj_data, inj_last,
             rxcmd_req, rxcmd_val,
      output ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt, inj_ready,
             reg_wr_stb, reg_wr_addr, reg_wr_data, tx_bytes
   );

   modport master (
      output ulpi_resetn, ulpi_data_i, ulpi_stp, inj_valid, inj_data, inj_last,
             rxcmd_req, rxcmd_val,
      input  ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt, inj_ready,
             reg_wr_stb, reg_wr_addr, reg_wr_data, tx_bytes
   );
endinterface

// File: rtl/ulpi_phy_model.sv
// rtl/ulpi_phy_model.sv - synthesizable ULPI PHY emulator (reg access, link TX, RX injection, RXCMD)
// Optional NXT throttling in the TX data phase: define ULPI_MODEL_THROTTLE_EN.
module ulpi_phy_model #(
   parameter int REG_ADDR_W   = 6,
   parameter int RESET_CYCLES = 8,
   parameter int NXT_DELAY    = 2,
   parameter int TXCNT_W      = 11
) (
   input logic          clk,
   input logic          rst,
   ulpi_phy_model_if.slave bus
);
   typedef enum logic [3:0] {
      RST_HOLD, LINK_RST, IDLE, TURN_UP, RX_DATA, RXCMD, CMD_WAIT,
      W_DATA, W_STP, R_TURN, R_DATA, T_DATA
   } state_t;

   localparam int                    NREGS     = 2 ** REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] EXT_ADDR  = REG_ADDR_W'(6'h2F);
   localparam logic [3:0]            WAIT_LOAD = (NXT_DELAY > 0) ? 4'(NXT_DELAY - 1) : 4'd0;
   localparam logic [15:0]           HOLD_LAST = (RESET_CYCLES > 0) ? 16'(RESET_CYCLES - 1) : 16'd0;

   state_t                state, state_nx;
   logic [15:0]           hold_cnt;
   logic [3:0]            wait_cnt;
   logic [1:0]            cmd_type;
   logic [REG_ADDR_W-1:0] cmd_addr;
   logic [7:0]            wdata;
   logic [7:0]            rxcmd_hold;
   logic                  inj_mode;
   logic [TXCNT_W-1:0]    tx_cnt;
   logic [7:0]            regs [NREGS];
   logic                  tx_nxt;

   function automatic logic [7:0] reg_init(input int idx);
      case (idx)
         0:       return 8'h24;
         1:       return 8'h04;
         2:       return 8'h06;
         4:       return 8'h41;
         10:      return 8'h06;
         default: return 8'h00;
      endcase
   endfunction

   function automatic state_t accept_state(input logic [1:0] t);
      case (t)
         2'b10:   return W_DATA;
         2'b11:   return R_TURN;
         default: return T_DATA;
      endcase
   endfunction

`ifdef ULPI_MODEL_THROTTLE_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign tx_nxt = ~lfsr[0];
`else
   assign tx_nxt = 1'b1;
`endif

   always_comb begin
      state_nx         = state;
      bus.ulpi_data_o  = 8'h00;
      bus.ulpi_data_oe = 1'b0;
      bus.ulpi_dir     = 1'b0;
      bus.ulpi_nxt     = 1'b0;
      bus.inj_ready    = 1'b0;
      case (state)
         RST_HOLD: begin
            bus.ulpi_dir = 1'b1;
            if (hold_cnt >= HOLD_LAST) state_nx = IDLE;
         end
         LINK_RST: begin
            bus.ulpi_dir = 1'b1;
            if (bus.ulpi_resetn) state_nx = RST_HOLD;
         end
         IDLE: begin
            // a link command seen in the same cycle the PHY takes the bus is dropped
            if (bus.inj_valid || bus.rxcmd_req) begin
               state_nx = TURN_UP;
            end else if (bus.ulpi_data_i[7:6] != 2'b00) begin
               if (NXT_DELAY == 0) begin
                  bus.ulpi_nxt = 1'b1;
                  state_nx     = accept_state(bus.ulpi_data_i[7:6]);
               end else begin
                  state_nx = CMD_WAIT;
               end
            end
         end
         CMD_WAIT: begin
            if (wait_cnt == 4'd0) begin
               bus.ulpi_nxt = 1'b1;
               state_nx     = accept_state(cmd_type);
            end
         end
         W_DATA: begin
            bus.ulpi_nxt = 1'b1;
            state_nx     = W_STP;
         end
         W_STP: begin
            if (bus.ulpi_stp) state_nx = IDLE;
         end
         R_TURN: begin
            bus.ulpi_dir = 1'b1;
            state_nx     = R_DATA;
         end
         R_DATA: begin
            bus.ulpi_dir     = 1'b1;
            bus.ulpi_data_oe = 1'b1;
            bus.ulpi_data_o  = regs[cmd_addr];
            state_nx         = IDLE;
         end
         T_DATA: begin
            bus.ulpi_nxt = tx_nxt;
            if (bus.ulpi_stp) state_nx = IDLE;
         end
         TURN_UP: begin
            bus.ulpi_dir = 1'b1;
            state_nx     = inj_mode ? RX_DATA : RXCMD;
         end
         RX_DATA: begin
            bus.ulpi_dir     = 1'b1;
            bus.ulpi_data_oe = 1'b1;
            if (bus.inj_valid) begin
               bus.ulpi_nxt    = 1'b1;
               bus.ulpi_data_o = bus.inj_data;
               bus.inj_ready   = 1'b1;
               if (bus.inj_last) state_nx = IDLE;
            end else begin
               bus.ulpi_data_o = bus.rxcmd_val;
            end
         end
         RXCMD: begin
            bus.ulpi_dir     = 1'b1;
            bus.ulpi_data_oe = 1'b1;
            bus.ulpi_data_o  = rxcmd_hold;
            state_nx         = IDLE;
         end
         default: state_nx = RST_HOLD;
      endcase
      if (!bus.ulpi_resetn) begin
         state_nx      = LINK_RST;
         bus.ulpi_nxt  = 1'b0;
         bus.inj_ready = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= RST_HOLD;
         hold_cnt        <= 16'd0;
         wait_cnt        <= 4'd0;
         cmd_type        <= 2'b00;
         cmd_addr        <= '0;
         wdata           <= 8'h00;
         rxcmd_hold      <= 8'h00;
         inj_mode        <= 1'b0;
         tx_cnt          <= '0;
         bus.tx_bytes    <= '0;
         bus.reg_wr_stb  <= 1'b0;
         bus.reg_wr_addr <= '0;
         bus.reg_wr_data <= 8'h00;
         for (int i = 0; i < NREGS; i++) regs[i] <= reg_init(i);
      end else begin
         state          <= state_nx;
         bus.reg_wr_stb <= 1'b0;
         if (!bus.ulpi_resetn) begin
            // the cycle that follows release already counts as the first hold cycle
            hold_cnt <= 16'd1;
            for (int i = 0; i < NREGS; i++) regs[i] <= reg_init(i);
         end else begin
            case (state)
               RST_HOLD: hold_cnt <= hold_cnt + 16'd1;
               IDLE: begin
                  inj_mode   <= bus.inj_valid;
                  rxcmd_hold <= bus.rxcmd_val;
                  cmd_type   <= bus.ulpi_data_i[7:6];
                  cmd_addr   <= bus.ulpi_data_i[REG_ADDR_W-1:0];
                  wait_cnt   <= WAIT_LOAD;
                  tx_cnt     <= '0;
               end
               CMD_WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
               W_DATA: wdata <= bus.ulpi_data_i;
               W_STP: begin
                  if (bus.ulpi_stp && cmd_addr != EXT_ADDR) begin
                     regs[cmd_addr]  <= wdata;
                     bus.reg_wr_stb  <= 1'b1;
                     bus.reg_wr_addr <= cmd_addr;
                     bus.reg_wr_data <= wdata;
                  end
               end
               T_DATA: begin
                  if (bus.ulpi_stp)
                     bus.tx_bytes <= tx_cnt;
                  else if (tx_nxt && tx_cnt != {TXCNT_W{1'b1}})
                     tx_cnt <= tx_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
